// File: rtl/bpsk_pkg.sv
// ----------------------------------------------------------------------------
// bpsk_pkg : shared FSM state type, sample limits and saturating negate
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

`ifndef CARRIER_SAMPLES_PER_PERIOD
`define CARRIER_SAMPLES_PER_PERIOD 8
`endif

package bpsk_pkg;

  localparam int CARRIER_SPP = `CARRIER_SAMPLES_PER_PERIOD;
  localparam int SAMPLE_W    = 12;

  localparam logic [SAMPLE_W-1:0] SAMPLE_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] SAMPLE_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } tx_seq_state_t;

  // The most negative code has no positive twin; clamp it instead of wrapping.
  function automatic logic [SAMPLE_W-1:0] neg_sat(input logic [SAMPLE_W-1:0] x);
    return (x == SAMPLE_MIN) ? SAMPLE_MAX : -x;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bpsk_tx_sequencer_phase_ctr.sv
// ----------------------------------------------------------------------------
// carrier_phase_ctr : LUT sample index and carrier period index for one symbol
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module carrier_phase_ctr
  import bpsk_pkg::*;
#(
  parameter int SPP = CARRIER_SPP,
  parameter int PPS = 4,
  localparam int SW = $clog2(SPP),
  localparam int PW = (PPS > 1) ? $clog2(PPS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          adv,
  output logic [SW-1:0] sidx,
  output logic [PW-1:0] pidx,
  output logic          last_of_symbol
);

  localparam logic [SW-1:0] SIDX_MAX = SW'(SPP - 1);
  localparam logic [PW-1:0] PIDX_MAX = PW'(PPS - 1);

  assign last_of_symbol = (sidx == SIDX_MAX) && (pidx == PIDX_MAX);

  // Wrapping on the last sample lands both counters on 0, which is exactly
  // where a back-to-back symbol has to start.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      sidx <= '0;
      pidx <= '0;
    end else if (adv) begin
      if (sidx == SIDX_MAX) begin
        sidx <= '0;
        pidx <= (pidx == PIDX_MAX) ? '0 : pidx + PW'(1);
      end else begin
        sidx <= sidx + SW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bpsk_tx_sequencer.sv
// ----------------------------------------------------------------------------
// bpsk_tx_sequencer : steps the cosine LUT phase and BPSK-modulates its samples
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bpsk_tx_sequencer #(
  parameter int SPP      = bpsk_pkg::CARRIER_SPP,
  parameter int PPS      = 4,
  parameter int SAMPLE_W = bpsk_pkg::SAMPLE_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    bit_valid,
  input  logic                    bit_data,
  output logic                    bit_ready,
  output logic [$clog2(SPP)-1:0]  lut_addr,
  input  logic [SAMPLE_W-1:0]     conv_sample,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SAMPLE_W-1:0]     out_sample,
  output logic                    busy,
  output logic                    underrun
);

  import bpsk_pkg::*;

  localparam int PW = (PPS > 1) ? $clog2(PPS) : 1;

  tx_seq_state_t state, next_state;

  logic          cur_bit;
  logic          adv;
  logic          last_of_symbol;
  logic [PW-1:0] unused_pidx;
  logic          load_bit;
  logic          load_out;
  logic          clear_out;
  logic          set_underrun;

  assign adv  = ~out_valid | out_ready;
  assign busy = (state != IDLE);

  // Counters sit at 0 outside RUN, so lut_addr presents phase 0 ahead of every symbol.
  carrier_phase_ctr #(
    .SPP (SPP),
    .PPS (PPS)
  ) u_phase_ctr (
    .clk            (clk),
    .rst_n          (rst_n),
    .clr            (state != RUN),
    .adv            (adv && (state == RUN)),
    .sidx           (lut_addr),
    .pidx           (unused_pidx),
    .last_of_symbol (last_of_symbol)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    bit_ready    = 1'b0;
    load_bit     = 1'b0;
    load_out     = 1'b0;
    clear_out    = 1'b0;
    set_underrun = 1'b0;
    unique case (state)
      IDLE: begin
        bit_ready = en;
        if (en && bit_valid) begin
          load_bit   = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        if (adv) begin
          load_out = 1'b1;
          if (last_of_symbol) begin
            if (en && bit_valid) begin
              bit_ready = 1'b1;
              load_bit  = 1'b1;
            end else begin
              set_underrun = en;
              next_state   = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if (out_valid && out_ready) begin
          clear_out  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_bit    <= 1'b0;
      out_valid  <= 1'b0;
      out_sample <= '0;
      underrun   <= 1'b0;
    end else begin
      if (load_bit) begin
        cur_bit <= bit_data;
      end
      // Uses the outgoing symbol's bit even on the edge a new bit is latched.
      if (load_out) begin
        out_sample <= cur_bit ? neg_sat(conv_sample) : conv_sample;
        out_valid  <= 1'b1;
      end else if (clear_out) begin
        out_valid <= 1'b0;
      end
      if (set_underrun) begin
        underrun <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
